// File: rtl/paddle_ctrl_pkg.sv
// Shared pong definitions: button direction and paddle FSM encodings, playfield size.
// The renderer and collision logic import the playfield constants from here.
package paddle_ctrl_pkg;

  localparam int PONG_FIELD_H  = 480;
  localparam int PONG_PADDLE_H = 64;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

endpackage

// File: rtl/paddle_step_clamp.sv
// Saturating move of a paddle position by a step, held inside [0, MAX_Y].
// Computed one bit wider than the position so the down sum cannot wrap.
module paddle_step_clamp
  import paddle_ctrl_pkg::*;
#(
  parameter int Y_W   = 10,
  parameter int S_W   = 3,
  parameter int MAX_Y = 416
) (
  input  logic [Y_W-1:0] y,
  input  logic [S_W-1:0] step,
  input  dir_e           dir,
  output logic [Y_W-1:0] y_next
);

  localparam logic [Y_W:0] MAX_EXT = (Y_W+1)'(MAX_Y);

  logic [Y_W:0] y_ext;
  logic [Y_W:0] step_ext;
  logic [Y_W:0] sum;
  logic [Y_W:0] diff;

  always_comb begin
    y_ext    = {1'b0, y};
    step_ext = (Y_W+1)'(step);
    sum      = y_ext + step_ext;
    diff     = y_ext - step_ext;
    y_next   = y;
    unique case (dir)
      DIR_UP:   y_next = (y_ext < step_ext) ? '0 : diff[Y_W-1:0];
      DIR_DOWN: y_next = (sum > MAX_EXT) ? MAX_EXT[Y_W-1:0] : sum[Y_W-1:0];
      default:  y_next = y;
    endcase
  end

endmodule

// File: rtl/paddle_ctrl.sv
// One player's paddle: press steps once, hold auto-repeats with stepped acceleration.
// state     | meaning
// ST_IDLE   | no button held (or held through a recenter); waits for a press edge
// ST_HOLD   | pressed and stepped once; counting ticks toward auto-repeat
// ST_REPEAT | auto-repeat: every tick steps by speed, speed ramps to MAX_SPEED
module paddle_ctrl
  import paddle_ctrl_pkg::*;
#(
  parameter int Y_W          = 10,
  parameter int FIELD_H      = PONG_FIELD_H,
  parameter int PADDLE_H     = PONG_PADDLE_H,
  parameter int REPEAT_DELAY = 8,
  parameter int ACCEL_TICKS  = 4,
  parameter int MAX_SPEED    = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           tick,
  input  logic           recenter,
  output logic [Y_W-1:0] paddle_y,
  output logic           moved,
  output logic           at_top,
  output logic           at_bottom
);

  localparam int MAX_Y  = FIELD_H - PADDLE_H;
  localparam int INIT_Y = MAX_Y / 2;
  localparam int DLY_W  = $clog2(REPEAT_DELAY);
  localparam int ACC_W  = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
  localparam int SPD_W  = $clog2(MAX_SPEED + 1);

  localparam logic [Y_W-1:0]   MAX_Y_V  = Y_W'(MAX_Y);
  localparam logic [Y_W-1:0]   INIT_Y_V = Y_W'(INIT_Y);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(REPEAT_DELAY - 1);
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
  localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACCEL_TICKS - 1);
  localparam logic [ACC_W-1:0] ACC_ONE  = ACC_W'(1);
  localparam logic [SPD_W-1:0] SPD_MAX  = SPD_W'(MAX_SPEED);
  localparam logic [SPD_W-1:0] SPD_ONE  = SPD_W'(1);

  state_e           state;
  dir_e             dir;
  dir_e             dir_q;
  logic [DLY_W-1:0] dly_cnt;
  logic [ACC_W-1:0] acc_cnt;
  logic [SPD_W-1:0] speed;

  logic             press_edge;
  logic             hold_done;
  logic             step_move;
  logic             y_load;
  logic [SPD_W-1:0] step;
  logic [Y_W-1:0]   y_step;
  logic [Y_W-1:0]   y_new;

  always_comb begin
    dir = DIR_NONE;
    if (btn_up && !btn_down)      dir = DIR_UP;
    else if (btn_down && !btn_up) dir = DIR_DOWN;
  end

  assign press_edge = (dir != DIR_NONE) && (dir != dir_q);
  assign hold_done  = (state == ST_HOLD) && (dly_cnt == DLY_LAST);
  assign step_move  = !recenter && !press_edge && (dir != DIR_NONE) && tick &&
                      (hold_done || (state == ST_REPEAT));
  assign step       = press_edge ? SPD_ONE : speed;
  assign y_load     = recenter || press_edge || step_move;
  assign y_new      = recenter ? INIT_Y_V : y_step;

  paddle_step_clamp #(
    .Y_W   (Y_W),
    .S_W   (SPD_W),
    .MAX_Y (MAX_Y)
  ) u_step_clamp (
    .y      (paddle_y),
    .step   (step),
    .dir    (dir),
    .y_next (y_step)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      dir_q     <= DIR_NONE;
      dly_cnt   <= '0;
      acc_cnt   <= '0;
      speed     <= SPD_ONE;
      paddle_y  <= INIT_Y_V;
      moved     <= 1'b0;
      at_top    <= 1'b0;
      at_bottom <= 1'b0;
    end else begin
      dir_q <= dir;
      moved <= 1'b0;
      if (y_load) begin
        paddle_y  <= y_new;
        moved     <= (y_new != paddle_y);
        at_top    <= (y_new == '0);
        at_bottom <= (y_new == MAX_Y_V);
      end

      if (recenter || press_edge || (dir == DIR_NONE)) begin
        state   <= recenter ? ST_IDLE : (press_edge ? ST_HOLD : ST_IDLE);
        speed   <= SPD_ONE;
        dly_cnt <= '0;
        acc_cnt <= '0;
      end else if (tick) begin
        case (state)
          ST_HOLD: begin
            if (!hold_done) dly_cnt <= dly_cnt + DLY_ONE;
          end
          default: ;
        endcase
        // The delay-expiry step counts as the first repeat move; acc_cnt is 0 and
        // speed is 1 throughout HOLD, so the same ramp logic serves both states.
        if (step_move) begin
          state <= ST_REPEAT;
          if (acc_cnt == ACC_LAST) begin
            acc_cnt <= '0;
            if (speed < SPD_MAX) speed <= speed + SPD_ONE;
          end else begin
            acc_cnt <= acc_cnt + ACC_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: per-cycle vector table plus wall, recenter and reset sequences.
module tb_paddle_ctrl;
  import paddle_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_up, btn_down, tick, recenter;
  logic [9:0] paddle_y;
  logic       moved, at_top, at_bottom;

  int n_vec = 0;
  int n_err = 0;

  paddle_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .tick      (tick),
    .recenter  (recenter),
    .paddle_y  (paddle_y),
    .moved     (moved),
    .at_top    (at_top),
    .at_bottom (at_bottom)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic up, dn, tk, rc;
    int   y;
    logic mv, top, bot;
  } vec_t;

  vec_t vecs[34];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic u, input logic d, input logic t, input logic r);
    btn_up = u; btn_down = d; tick = t; recenter = r;
    @(posedge clk);
    #1;
  endtask

  int moves;

  initial begin
    // up dn tk rc   y    mv top bot
    vecs[0]  = '{0, 0, 1, 0, 208, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 208, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 0, 207, 1, 0, 0};
    vecs[3]  = '{1, 0, 0, 0, 207, 0, 0, 0};
    vecs[4]  = '{1, 0, 0, 0, 207, 0, 0, 0};
    vecs[5]  = '{0, 0, 0, 0, 207, 0, 0, 0};
    vecs[6]  = '{0, 1, 0, 0, 208, 1, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 208, 0, 0, 0};
    vecs[8]  = '{0, 1, 1, 0, 209, 1, 0, 0};
    for (int i = 9; i <= 15; i++) vecs[i] = '{0, 1, 1, 0, 209, 0, 0, 0};
    vecs[16] = '{0, 1, 1, 0, 210, 1, 0, 0};
    vecs[17] = '{0, 1, 1, 0, 211, 1, 0, 0};
    vecs[18] = '{0, 1, 1, 0, 212, 1, 0, 0};
    vecs[19] = '{0, 1, 1, 0, 213, 1, 0, 0};
    vecs[20] = '{0, 1, 1, 0, 215, 1, 0, 0};
    vecs[21] = '{0, 1, 1, 0, 217, 1, 0, 0};
    vecs[22] = '{0, 1, 1, 0, 219, 1, 0, 0};
    vecs[23] = '{0, 1, 1, 0, 221, 1, 0, 0};
    vecs[24] = '{0, 1, 1, 0, 224, 1, 0, 0};
    vecs[25] = '{0, 1, 0, 0, 224, 0, 0, 0};
    vecs[26] = '{0, 1, 1, 0, 227, 1, 0, 0};
    vecs[27] = '{1, 1, 1, 0, 227, 0, 0, 0};
    vecs[28] = '{1, 1, 1, 0, 227, 0, 0, 0};
    vecs[29] = '{0, 1, 0, 0, 228, 1, 0, 0};
    vecs[30] = '{0, 1, 0, 0, 228, 0, 0, 0};
    vecs[31] = '{0, 0, 0, 0, 228, 0, 0, 0};
    vecs[32] = '{0, 0, 0, 1, 208, 1, 0, 0};
    vecs[33] = '{0, 0, 0, 1, 208, 0, 0, 0};

    reset_n = 1'b0;
    btn_up = 0; btn_down = 0; tick = 0; recenter = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("reset_y", int'(paddle_y), 208);
    chk("reset_flags", int'({moved, at_top, at_bottom}), 0);
    chk("reset_state", int'(dut.state), int'(ST_IDLE));
    chk("reset_speed", int'(dut.speed), 1);

    for (int i = 0; i < 34; i++) begin
      cyc(vecs[i].up, vecs[i].dn, vecs[i].tk, vecs[i].rc);
      chk($sformatf("vec%0d_y", i), int'(paddle_y), vecs[i].y);
      chk($sformatf("vec%0d_flags", i), int'({moved, at_top, at_bottom}),
          int'({vecs[i].mv, vecs[i].top, vecs[i].bot}));
      if (i == 28) chk("both_state", int'(dut.state), int'(ST_IDLE));
    end

    // Wall clamp at the top, hit while repeating at speed 3
    cyc(0, 0, 0, 0);
    for (int k = 0; k < 300 && paddle_y != 0; k++) cyc(1, 0, 1, 0);
    chk("reach_top_y", int'(paddle_y), 0);
    chk("reach_top_flag", int'(at_top), 1);
    cyc(0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
    end
    chk("down20_y", int'(paddle_y), 20);
    chk("down20_top", int'(at_top), 0);
    cyc(1, 0, 0, 0);
    chk("wall_edge_y", int'(paddle_y), 19);
    for (int t = 1; t <= 7; t++) cyc(1, 0, 1, 0);
    chk("wall_delay_y", int'(paddle_y), 19);
    for (int t = 8; t <= 11; t++) cyc(1, 0, 1, 0);
    chk("wall_t11_y", int'(paddle_y), 15);
    for (int t = 12; t <= 15; t++) cyc(1, 0, 1, 0);
    chk("wall_t15_y", int'(paddle_y), 7);
    chk("wall_t15_speed", int'(dut.speed), 3);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    chk("wall_t17_y", int'(paddle_y), 1);
    cyc(1, 0, 1, 0);
    chk("wall_t18_y", int'(paddle_y), 0);
    chk("wall_t18_flags", int'({moved, at_top, at_bottom}), 3'b110);
    cyc(1, 0, 1, 0);
    chk("wall_t19_flags", int'({moved, at_top, at_bottom}), 3'b010);
    chk("wall_t19_speed", int'(dut.speed), 4);
    chk("wall_t19_state", int'(dut.state), int'(ST_REPEAT));
    cyc(1, 0, 1, 0);
    chk("wall_t20_y", int'(paddle_y), 0);
    chk("wall_t20_moved", int'(moved), 0);
    cyc(0, 0, 0, 0);

    // Bottom wall, then recenter coinciding with a tick while down is held
    for (int k = 0; k < 300 && paddle_y != 416; k++) cyc(0, 1, 1, 0);
    chk("reach_bot_y", int'(paddle_y), 416);
    chk("reach_bot_flag", int'(at_bottom), 1);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("bot_press_flags", int'({moved, at_top, at_bottom}), 3'b001);
    chk("bot_press_y", int'(paddle_y), 416);
    cyc(0, 0, 0, 0);
    for (int k = 0; k < 17; k++) begin
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
    chk("up17_y", int'(paddle_y), 399);
    cyc(0, 1, 0, 0);
    chk("rc_edge_y", int'(paddle_y), 400);
    cyc(0, 1, 1, 0);
    chk("rc_hold_y", int'(paddle_y), 400);
    cyc(0, 1, 1, 1);
    chk("rc_y", int'(paddle_y), 208);
    chk("rc_moved", int'(moved), 1);
    chk("rc_state", int'(dut.state), int'(ST_IDLE));
    moves = 0;
    for (int k = 0; k < 12; k++) begin
      cyc(0, 1, 1, 0);
      if (moved) moves++;
    end
    chk("rc_held_moves", moves, 0);
    chk("rc_held_y", int'(paddle_y), 208);

    // Asynchronous reset in the middle of a cycle
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("pre_reset_y", int'(paddle_y), 209);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_y", int'(paddle_y), 208);
    chk("async_reset_moved", int'(moved), 0);
    btn_down = 0;
    #1 reset_n = 1'b1;
    cyc(0, 0, 1, 0);
    chk("post_reset_y", int'(paddle_y), 208);
    chk("post_reset_state", int'(dut.state), int'(ST_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
